time_display_scan: RTL and testbench

TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

---
 rtl/time_display_scan_if.sv | 20 ++
 rtl/time_display_scan.sv | 134 +++++++++++++
 tb/tb_time_display_scan.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/time_display_scan_if.sv
// Bus between the alarm-clock stage and the six-digit multiplexed display scanner.
interface time_display_scan_if;
  logic [23:0] num_in;
  logic        blink_hour;
  logic        blink_min;
  logic [5:0]  dig_sel;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  modport master (
    output num_in, blink_hour, blink_min,
    input  dig_sel, seg, dp, frame_start
  );

  modport slave (
    input  num_in, blink_hour, blink_min,
    output dig_sel, seg, dp, frame_start
  );
endinterface

// File: rtl/time_display_scan.sv
// Six-digit hh.mm.ss scanner: snapshots the BCD time once per frame, multiplexes the
// digits with a per-digit dwell, and applies leading-zero and field-blink blanking.
module time_display_scan #(
  parameter int DWELL       = 2,
  parameter int BLINK_HALF  = 250,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  time_display_scan_if.slave   bus
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [9:0] BLINK_LAST = 10'(BLINK_HALF - 1);

  logic        loaded_q,      loaded_d;
  logic [2:0]  idx_q,         idx_d;
  logic [7:0]  dwell_q,       dwell_d;
  logic [23:0] snap_q,        snap_d;
  logic [9:0]  blink_cnt_q,   blink_cnt_d;
  logic        phase_q,       phase_d;
  logic [5:0]  dig_sel_q,     dig_sel_d;
  logic [6:0]  seg_q,         seg_d;
  logic        dp_q,          dp_d;
  logic        frame_start_q, frame_start_d;

  logic [3:0]  nib;
  logic        blank;

  // Non-decimal or unknown nibbles (e.g. a floating seconds byte) fall through to blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
    case (n)
      4'd0:    bcd_to_seg = 7'b0111111;
      4'd1:    bcd_to_seg = 7'b0000110;
      4'd2:    bcd_to_seg = 7'b1011011;
      4'd3:    bcd_to_seg = 7'b1001111;
      4'd4:    bcd_to_seg = 7'b1100110;
      4'd5:    bcd_to_seg = 7'b1101101;
      4'd6:    bcd_to_seg = 7'b1111101;
      4'd7:    bcd_to_seg = 7'b0000111;
      4'd8:    bcd_to_seg = 7'b1111111;
      4'd9:    bcd_to_seg = 7'b1101111;
      default: bcd_to_seg = 7'b0000000;
    endcase
  endfunction

  function automatic logic [3:0] pick_nibble(input logic [23:0] s, input logic [2:0] i);
    case (i)
      3'd0:    pick_nibble = s[23:20];
      3'd1:    pick_nibble = s[19:16];
      3'd2:    pick_nibble = s[15:12];
      3'd3:    pick_nibble = s[11:8];
      3'd4:    pick_nibble = s[7:4];
      3'd5:    pick_nibble = s[3:0];
      default: pick_nibble = 4'hF;
    endcase
  endfunction

  always_comb begin
    loaded_d      = 1'b1;
    idx_d         = idx_q;
    dwell_d       = dwell_q;
    snap_d        = snap_q;
    dig_sel_d     = 6'b111111;
    seg_d         = 7'b0000000;
    dp_d          = 1'b0;
    frame_start_d = 1'b0;
    blink_cnt_d   = blink_cnt_q + 10'd1;
    phase_d       = phase_q;

    nib   = pick_nibble(snap_q, idx_q);
    blank = (LZ_SUPPRESS && (idx_q == 3'd0) && (nib == 4'd0)) ||
            (!phase_q && ((bus.blink_hour && (idx_q <= 3'd1)) ||
                          (bus.blink_min  && ((idx_q == 3'd2) || (idx_q == 3'd3)))));

    // The first cycle out of reset only captures the time; scanning starts on the next.
    if (!loaded_q) begin
      snap_d = bus.num_in;
    end else begin
      dig_sel_d     = ~(6'b000001 << idx_q);
      seg_d         = blank ? 7'b0000000 : bcd_to_seg(nib);
      dp_d          = phase_q && ((idx_q == 3'd1) || (idx_q == 3'd3));
      frame_start_d = (idx_q == 3'd0) && (dwell_q == 8'd0);
      if (dwell_q == DWELL_LAST) begin
        dwell_d = 8'd0;
        if (idx_q == 3'd5) begin
          idx_d  = 3'd0;
          snap_d = bus.num_in;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        dwell_d = dwell_q + 8'd1;
      end
    end

    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = 10'd0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q      <= 1'b0;
      idx_q         <= 3'd0;
      dwell_q       <= 8'd0;
      snap_q        <= 24'd0;
      blink_cnt_q   <= 10'd0;
      phase_q       <= 1'b1;
      dig_sel_q     <= 6'b111111;
      seg_q         <= 7'b0000000;
      dp_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      loaded_q      <= loaded_d;
      idx_q         <= idx_d;
      dwell_q       <= dwell_d;
      snap_q        <= snap_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      dig_sel_q     <= dig_sel_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.dig_sel     = dig_sel_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan: two instances (DWELL=2 and DWELL=1, BLINK_HALF=4)
// share one stimulus stream; expected outputs come from edge counts since reset release.
module tb_time_display_scan;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] num;
  logic        bh;
  logic        bm;

  int total = 0;
  int bad   = 0;

  int          k;
  int          last_fs;
  logic [23:0] snap_a;
  logic [23:0] snap_c;

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  time_display_scan_if ifa ();
  time_display_scan_if ifc ();

  assign ifa.num_in     = num;
  assign ifa.blink_hour = bh;
  assign ifa.blink_min  = bm;
  assign ifc.num_in     = num;
  assign ifc.blink_hour = bh;
  assign ifc.blink_min  = bm;

  time_display_scan #(.DWELL(2), .BLINK_HALF(4), .LZ_SUPPRESS(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  time_display_scan #(.DWELL(1), .BLINK_HALF(4), .LZ_SUPPRESS(1'b1)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string nm, input logic [5:0] dig, input logic [6:0] sg,
                            input logic p, input logic fs);
    chk({nm, "_dig"}, 32'(dig), 32'h3F);
    chk({nm, "_seg"}, 32'(sg), 32'h0);
    chk({nm, "_dp"},  32'(p),  32'h0);
    chk({nm, "_fs"},  32'(fs), 32'h0);
  endtask

  // kk = scanning edge number (1 = first edge that shows digit 0 after reset release).
  task automatic check_inst(input string nm, input int dw, input int kk, input logic [23:0] snap,
                            input logic hb, input logic mb, input logic [5:0] dig,
                            input logic [6:0] sg, input logic p, input logic fs);
    int         d;
    logic [3:0] nib;
    logic       ph;
    logic [6:0] es;
    logic [5:0] ed;
    d   = ((kk - 1) / dw) % 6;
    nib = snap[23 - 4*d -: 4];
    ph  = ((kk / 4) % 2) == 0;
    if ($isunknown(nib) || nib > 4'd9) es = 7'h00;
    else                               es = segtab[nib];
    if (d == 0 && nib == 4'd0) es = 7'h00;
    if (!ph && ((hb && d < 2) || (mb && (d == 2 || d == 3)))) es = 7'h00;
    ed = ~(6'b000001 << d);
    chk($sformatf("%s_dig@%0d", nm, kk), 32'(dig), 32'(ed));
    chk($sformatf("%s_seg@%0d", nm, kk), 32'(sg),  32'(es));
    chk($sformatf("%s_dp@%0d",  nm, kk), 32'(p),   32'(ph && (d == 1 || d == 3)));
    chk($sformatf("%s_fs@%0d",  nm, kk), 32'(fs),  32'(d == 0 && ((kk - 1) % dw) == 0));
    chk($sformatf("%s_segx@%0d", nm, kk), 32'($isunknown(sg)), 32'h0);
  endtask

  task automatic tick();
    logic [23:0] n;
    logic        r;
    logic        hb;
    logic        mb;
    int          kk;
    n  = num;
    r  = rst;
    hb = bh;
    mb = bm;
    @(posedge clk);
    @(negedge clk);
    if (r) begin
      k       = 0;
      snap_a  = 24'h0;
      snap_c  = 24'h0;
      last_fs = -1;
      check_idle("A_rst", ifa.dig_sel, ifa.seg, ifa.dp, ifa.frame_start);
      check_idle("C_rst", ifc.dig_sel, ifc.seg, ifc.dp, ifc.frame_start);
    end else begin
      k++;
      if (k == 1) begin
        check_idle("A_load", ifa.dig_sel, ifa.seg, ifa.dp, ifa.frame_start);
        check_idle("C_load", ifc.dig_sel, ifc.seg, ifc.dp, ifc.frame_start);
        snap_a = n;
        snap_c = n;
      end else begin
        kk = k - 1;
        check_inst("A", 2, kk, snap_a, hb, mb, ifa.dig_sel, ifa.seg, ifa.dp, ifa.frame_start);
        check_inst("C", 1, kk, snap_c, hb, mb, ifc.dig_sel, ifc.seg, ifc.dp, ifc.frame_start);
        if (ifa.frame_start) begin
          if (last_fs >= 0) chk("A_fs_period", 32'(kk - last_fs), 32'd12);
          last_fs = kk;
        end
        // A wrap edge reloads the snapshot from the value present at that edge.
        if (kk % 12 == 0) snap_a = n;
        if (kk % 6 == 0)  snap_c = n;
      end
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; num = 24'h123456; bh = 1'b0; bm = 1'b0;
    k = 0; last_fs = -1; snap_a = 24'h0; snap_c = 24'h0;
    tick_n(3);
    rst = 1'b0;
    tick_n(1 + 36);

    // Time changes while digit 3 is on screen; the frame in progress must not tear.
    rst = 1'b1; num = 24'h095959; tick();
    rst = 1'b0; tick_n(1 + 7);
    num = 24'h100000;
    tick_n(24);

    // Seconds byte floating (set modes).
    rst = 1'b1; num = {16'h0712, 8'hzz}; tick();
    rst = 1'b0; tick_n(1 + 14);

    // Minute field blinking, then hour and minute together.
    rst = 1'b1; num = 24'h123456; tick();
    rst = 1'b0; bm = 1'b1; tick_n(1 + 26);
    bh = 1'b1; tick_n(16);
    bh = 1'b0; bm = 1'b0;

    // One-cycle reset while the DWELL=2 instance sits on digit 4.
    rst = 1'b1; tick();
    rst = 1'b0; tick_n(1 + 9);
    rst = 1'b1; tick();
    rst = 1'b0; tick_n(2);
    chk("mid_rst_dig", 32'(ifa.dig_sel), 32'h3E);
    chk("mid_rst_fs",  32'(ifa.frame_start), 32'h1);
    tick_n(12);

    // All-hex time: every digit blank, scanning continues.
    rst = 1'b1; num = 24'hABCDEF; tick();
    rst = 1'b0; tick_n(1 + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
